// File: rtl/ispm_way_cfg_ctrl_pkg.sv
// Shared types and helpers for the I-SPM way configuration controller.
package ispm_way_cfg_ctrl_pkg;

    // Controller phases: wait for a request, drain fetch, scrub lines, publish.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SCRUB = 2'd2,
        DONE  = 2'd3
    } ispm_cfg_state_t;

    // Default raw way-memory word width (tag + line).
    localparam int unsigned DEF_MEMORY_WIDTH = 173;

    // Byte-enable width of a way-memory word of w bits.
    function automatic int unsigned be_width(input int unsigned w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/ispm_way_cfg_ctrl_if.sv
// Bus bundle of the way configuration controller: the configuration handshake,
// the fetch drain handshake, the scrub write port and a state debug tap.
interface ispm_way_cfg_ctrl_if
    import ispm_way_cfg_ctrl_pkg::*;
#(
    parameter int unsigned NR_WAYS      = 4,
    parameter int unsigned NR_LINES     = 256,
    parameter int unsigned MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int unsigned LINE_ADDR_W  = $clog2(NR_LINES)
);
    localparam int unsigned BE_W = be_width(MEMORY_WIDTH);

    // Handshakes: a configuration transfers in a cycle where cfg_valid_i and
    // cfg_ready_o are both high; the requester holds cfg_valid_i/cfg_ways_i
    // stable until then. A scrub write to way i completes in a cycle where
    // mem_req_o[i] and mem_gnt_i[i] are both high; un-granted requests persist.
    logic                    cfg_valid_i;
    logic [NR_WAYS-1:0]      cfg_ways_i;
    logic                    cfg_ready_o;
    logic [NR_WAYS-1:0]      active_ways_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    flush_req_o;
    logic                    flush_ack_i;
    logic [NR_WAYS-1:0]      mem_req_o;
    logic [NR_WAYS-1:0]      mem_gnt_i;
    logic [LINE_ADDR_W-1:0]  mem_addr_o;
    logic                    mem_we_o;
    logic [MEMORY_WIDTH-1:0] mem_wdata_o;
    logic [BE_W-1:0]         mem_be_o;
    logic [1:0]              dbg_state_o;

    // Controller side.
    modport slave (
        input  cfg_valid_i, cfg_ways_i, flush_ack_i, mem_gnt_i,
        output cfg_ready_o, active_ways_o, busy_o, done_o, flush_req_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
               dbg_state_o
    );

    // Requester / memory side.
    modport master (
        output cfg_valid_i, cfg_ways_i, flush_ack_i, mem_gnt_i,
        input  cfg_ready_o, active_ways_o, busy_o, done_o, flush_req_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
               dbg_state_o
    );

endinterface

// File: rtl/ispm_way_cfg_ctrl.sv
// Switches I-cache ways between cache and SPM mode: drains the fetch path,
// zero-scrubs every line of each way changing mode, then publishes the mask.
module ispm_way_cfg_ctrl
    import ispm_way_cfg_ctrl_pkg::*;
#(
    parameter int unsigned NR_WAYS      = 4,
    parameter int unsigned NR_LINES     = 256,
    parameter int unsigned MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int unsigned LINE_ADDR_W  = $clog2(NR_LINES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ispm_way_cfg_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_SCRUB = SCRUB;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [LINE_ADDR_W-1:0] LAST_LINE = LINE_ADDR_W'(NR_LINES - 1);

    logic [1:0]             r_state;
    logic [NR_WAYS-1:0]     r_tgt;
    logic [NR_WAYS-1:0]     r_chg;
    logic [NR_WAYS-1:0]     r_pend;
    logic [NR_WAYS-1:0]     r_active;
    logic [LINE_ADDR_W-1:0] r_line;

    logic [NR_WAYS-1:0]     w_chg;
    logic [NR_WAYS-1:0]     w_pend_d;
    logic                   w_last_line;
    logic [NR_WAYS-1:0]     w_mem_req;

    // Ways whose mode flips, remaining writes of the current line, last-line flag.
    always_comb begin
        w_chg       = bus.cfg_ways_i ^ r_active;
        w_pend_d    = r_pend & ~bus.mem_gnt_i;
        w_last_line = (r_line == LAST_LINE);
        w_mem_req   = (r_state == ST_SCRUB) ? r_pend : '0;
    end

    // Sequencer: state, masks and the line counter (terminal compare precedes increment).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_tgt    <= '0;
            r_chg    <= '0;
            r_pend   <= '0;
            r_active <= '0;
            r_line   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_valid_i) begin
                        r_tgt <= bus.cfg_ways_i;
                        r_chg <= w_chg;
                        if (w_chg == '0) begin
                            r_active <= bus.cfg_ways_i;
                            r_state  <= ST_DONE;
                        end else begin
                            // Changing ways leave service before anything touches them.
                            r_active <= r_active & ~w_chg;
                            r_state  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.flush_ack_i) begin
                        r_line  <= '0;
                        r_pend  <= r_chg;
                        r_state <= ST_SCRUB;
                    end
                end
                ST_SCRUB: begin
                    if (w_pend_d == '0) begin
                        if (w_last_line) begin
                            r_active <= r_tgt;
                            r_line   <= '0;
                            r_pend   <= '0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_line <= r_line + 1'b1;
                            r_pend <= r_chg;
                        end
                    end else begin
                        // Hold the line and retry only the ways not yet granted.
                        r_pend <= w_pend_d;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; scrub writes are always full-width zeros.
    always_comb begin
        bus.cfg_ready_o   = (r_state == ST_IDLE);
        bus.busy_o        = (r_state == ST_DRAIN) || (r_state == ST_SCRUB);
        bus.flush_req_o   = (r_state == ST_DRAIN) || (r_state == ST_SCRUB);
        bus.done_o        = (r_state == ST_DONE);
        bus.active_ways_o = r_active;
        bus.mem_req_o     = w_mem_req;
        bus.mem_addr_o    = r_line;
        bus.mem_we_o      = |w_mem_req;
        bus.mem_wdata_o   = '0;
        bus.mem_be_o      = '1;
        bus.dbg_state_o   = r_state;
    end

endmodule

// File: tb/tb_ispm_way_cfg_ctrl.sv
// Bench for the way configuration controller: vector table of configuration
// requests, a write scoreboard, and a hand-written mid-scrub reset sequence.
module tb_ispm_way_cfg_ctrl;
    import ispm_way_cfg_ctrl_pkg::*;

    localparam int NR_WAYS  = 4;
    localparam int NR_LINES = 256;
    localparam int MW       = 173;
    localparam int SB_W     = 10;   // {way[1:0], line[7:0]}
    localparam int BUDGET   = 2000;

    typedef struct {
        logic [3:0] ways;
        int         ack_dly;
        int         gmode;     // 0 full grant, 1 alternating 0001/0010, 2 random
        logic [3:0] exp_chg;
        logic [3:0] exp_mid;
        logic [3:0] exp_fin;
        int         exp_done;  // cycles accept->done, -1 when grant-dependent
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ispm_way_cfg_ctrl_if #(.NR_WAYS(NR_WAYS), .NR_LINES(NR_LINES), .MEMORY_WIDTH(MW)) cif ();

    ispm_way_cfg_ctrl #(
        .NR_WAYS(NR_WAYS), .NR_LINES(NR_LINES), .MEMORY_WIDTH(MW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (cif)
    );

    int total = 0;
    int bad   = 0;
    logic [SB_W-1:0] exp_q[$];

    bit   in_op, acc_seen, done_seen, mid_checked, ack_seen, req_seen;
    int   acc_cyc, done_cyc, done_cnt, ack_cyc, req_cyc, flush_cycles, req_cycles;
    logic [3:0] cur_chg, cur_mid, cur_fin;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_active"},  32'(cif.active_ways_o), 0);
        check({tag, "_ready"},   32'(cif.cfg_ready_o),   1);
        check({tag, "_busy"},    32'(cif.busy_o),        0);
        check({tag, "_done"},    32'(cif.done_o),        0);
        check({tag, "_flush"},   32'(cif.flush_req_o),   0);
        check({tag, "_mem_req"}, 32'(cif.mem_req_o),     0);
        check({tag, "_addr"},    32'(cif.mem_addr_o),    0);
        check({tag, "_state"},   32'(cif.dbg_state_o),   32'(IDLE));
    endtask

    // Sampled on the falling edge, away from the DUT's active edge.
    task automatic mon_step();
        logic [3:0] w;
        logic [SB_W-1:0] e;
        check("ready", 32'(cif.cfg_ready_o), 32'(!in_op));
        if (cif.cfg_valid_i && cif.cfg_ready_o && !acc_seen) begin
            acc_seen = 1; acc_cyc = cyc; in_op = 1;
        end
        if (cif.busy_o && !mid_checked) begin
            mid_checked = 1;
            check("active_mid", 32'(cif.active_ways_o), 32'(cur_mid));
        end
        if (cif.flush_req_o) flush_cycles++;
        if (cif.flush_req_o && cif.flush_ack_i && !ack_seen) begin
            ack_seen = 1; ack_cyc = cyc;
        end
        if (cif.mem_req_o != 4'b0) begin
            req_cycles++;
            if (!req_seen) begin req_seen = 1; req_cyc = cyc; end
            check("req_outside_chg", 32'(cif.mem_req_o & ~cur_chg), 0);
            check("we", 32'(cif.mem_we_o), 1);
            check("flush_in_scrub", 32'(cif.flush_req_o), 1);
        end
        w = cif.mem_req_o & cif.mem_gnt_i;
        for (int i = 0; i < NR_WAYS; i++) begin
            if (w[i]) begin
                check("wdata_zero", 32'(|cif.mem_wdata_o), 0);
                check("be_ones", 32'(&cif.mem_be_o), 1);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_write: got way %0d line %0d expected none", i, cif.mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("write", 32'({2'(i), cif.mem_addr_o}), 32'(e));
                end
            end
        end
        if (cif.done_o) begin
            if (!done_seen) done_cyc = cyc;
            done_seen = 1; done_cnt++; in_op = 0;
            check("active_at_done", 32'(cif.active_ways_o), 32'(cur_fin));
        end
    endtask

    task automatic run_cfg(input vec_t v, input int abort_line, output bit aborted);
        int n, drain_cnt, phase;
        cur_chg = v.exp_chg; cur_mid = v.exp_mid; cur_fin = v.exp_fin;
        acc_seen = 0; done_seen = 0; done_cnt = 0; mid_checked = 0;
        ack_seen = 0; req_seen = 0; flush_cycles = 0; req_cycles = 0;
        for (int l = 0; l < NR_LINES; l++)
            for (int i = 0; i < NR_WAYS; i++)
                if (v.exp_chg[i]) exp_q.push_back({2'(i), 8'(l)});
        cif.cfg_ways_i  = v.ways;
        cif.cfg_valid_i = 1'b1;
        n = 0; drain_cnt = 0; phase = 0; aborted = 0;
        while (!done_seen && n < BUDGET) begin
            @(posedge clk); #1; n++;
            if (acc_seen) cif.cfg_valid_i = 1'b0;
            if (cif.flush_req_o) begin
                cif.flush_ack_i = (drain_cnt >= v.ack_dly);
                drain_cnt++;
            end else begin
                cif.flush_ack_i = 1'b0;
            end
            case (v.gmode)
                0: cif.mem_gnt_i = 4'b1111;
                1: begin
                    if (cif.mem_req_o != 4'b0) begin
                        cif.mem_gnt_i = phase[0] ? 4'b0010 : 4'b0001;
                        phase++;
                    end else begin
                        cif.mem_gnt_i = 4'b0000;
                    end
                end
                default: cif.mem_gnt_i = 4'($urandom_range(0, 15));
            endcase
            if (abort_line >= 0 && cif.mem_req_o != 4'b0 && int'(cif.mem_addr_o) == abort_line) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) return;
        cif.mem_gnt_i = 4'b0; cif.flush_ack_i = 1'b0; cif.cfg_valid_i = 1'b0;
        if (!done_seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done_o in %0d cycles expected done", BUDGET);
            return;
        end
        if (v.exp_done >= 0) check("done_latency", 32'(done_cyc - acc_cyc), 32'(v.exp_done));
        check("done_pulses", 32'(done_cnt), 1);
        check("writes_left", 32'(exp_q.size()), 0);
        check("active_final", 32'(cif.active_ways_o), 32'(v.exp_fin));
        if (v.exp_chg == 4'b0) begin
            check("no_flush", 32'(flush_cycles), 0);
            check("no_mem_req", 32'(req_cycles), 0);
        end else begin
            check("scrub_after_ack", 32'(req_cyc - ack_cyc), 1);
        end
    endtask

    initial begin
        bit ab;
        vec_t va, vf;
        //            ways     ack gm  chg      mid      fin      done
        vecs[0] = '{4'b0011,  0, 0, 4'b0011, 4'b0000, 4'b0011, 258};
        vecs[1] = '{4'b0110,  0, 0, 4'b0101, 4'b0010, 4'b0110, 258};
        vecs[2] = '{4'b0110,  0, 0, 4'b0000, 4'b0110, 4'b0110,   1};
        vecs[3] = '{4'b0100, 10, 0, 4'b0010, 4'b0100, 4'b0100, 268};
        vecs[4] = '{4'b0111,  0, 1, 4'b0011, 4'b0100, 4'b0111, 514};
        vecs[5] = '{4'b1111,  0, 2, 4'b1000, 4'b0111, 4'b1111,  -1};
        vecs[6] = '{4'b0000,  0, 0, 4'b1111, 4'b0000, 4'b0000, 258};
        va      = '{4'b1111,  0, 0, 4'b1111, 4'b0000, 4'b1111, 258};
        vf      = '{4'b0001,  0, 0, 4'b0001, 4'b0000, 4'b0001, 258};

        cif.cfg_valid_i = 1'b0; cif.cfg_ways_i = 4'b0;
        cif.flush_ack_i = 1'b0; cif.mem_gnt_i  = 4'b0;
        in_op = 0; cur_chg = 4'b0; cur_mid = 4'b0; cur_fin = 4'b0;
        fork
            forever begin @(negedge clk); mon_step(); end
        join_none

        repeat (3) @(posedge clk);
        #1 check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_cfg(vecs[k], -1, ab);
            repeat (2) @(posedge clk); #1;
        end

        // Reset in the middle of a scrub, then a fresh request.
        run_cfg(va, 100, ab);
        check("abort_reached", 32'(ab), 1);
        cif.cfg_valid_i = 1'b0; cif.mem_gnt_i = 4'b0; cif.flush_ack_i = 1'b0;
        rst_n = 1'b0;
        in_op = 0;
        exp_q.delete();
        #1 check_reset("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_cfg(vf, -1, ab);
        repeat (2) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
